// File: rtl/sysid_checker.sv
// Purpose : Avalon-MM master that reads sysid words 0 (ID) and 1 (timestamp) and flags pass/fail.
// Latency : min check = 2 read cycles + 1 settle cycle; +1 cycle per wait state, +READ_LATENCY per read.
// Backpr. : holds address/read stable while avm_waitrequest=1; aborts after TIMEOUT_CYCLES stall cycles.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             one-cycle request for a new check (ignored while busy)
//   avm_address/read  word address and read strobe to the sysid slave
//   avm_waitrequest   slave stall, avm_readdata read data
//   busy, done        check in progress / last check finished with valid results
//   id_match/ts_match captured words equal the expected values
//   timeout_err       last check aborted by the stall timeout
//   sys_id/sys_timestamp  captured words 0 and 1
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523851750,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 1024,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic [31:0] sys_id,
    output logic [31:0] sys_timestamp
);

    localparam int STALL_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    // The abort decision is taken during the last permitted stall cycle so that
    // avm_read is already low in the cycle where the count equals TIMEOUT_CYCLES.
    localparam logic [STALL_W-1:0] STALL_LAST =
        (TIMEOUT_CYCLES > 0) ? STALL_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               auto_pend;
    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]         lat_cnt;
    logic               to_flag;

    logic cap_id;
    logic cap_ts;
    logic lat_start;
    logic to_hit;
    logic stall_hit;
    logic stall_en;
    logic done_hold;

    always_comb begin
        state_nxt = state;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        lat_start = 1'b0;
        to_hit    = 1'b0;
        stall_hit = (TIMEOUT_CYCLES != 0) && (stall_cnt == STALL_LAST);
        stall_en  = ((state == S_RD_ID) || (state == S_RD_TS)) && avm_waitrequest;
        case (state)
            S_IDLE: begin
                if (start || auto_pend) begin
                    state_nxt = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        cap_id    = 1'b1;
                        state_nxt = S_RD_TS;
                    end else begin
                        lat_start = 1'b1;
                        state_nxt = S_LAT_ID;
                    end
                end else if (stall_hit) begin
                    to_hit    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_LAT_ID: begin
                if (lat_cnt == LAT) begin
                    cap_id    = 1'b1;
                    state_nxt = S_RD_TS;
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        cap_ts    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        lat_start = 1'b1;
                        state_nxt = S_LAT_TS;
                    end
                end else if (stall_hit) begin
                    to_hit    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_LAT_TS: begin
                if (lat_cnt == LAT) begin
                    cap_ts    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RD_ID;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Result flags are compared from the captured registers one cycle after
        // DONE is entered; a restart clears them together with busy rising.
        done_hold = (state == S_DONE) && (state_nxt == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            auto_pend     <= AUTO_START;
            stall_cnt     <= '0;
            lat_cnt       <= '0;
            to_flag       <= 1'b0;
            avm_read      <= 1'b0;
            avm_address   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_match      <= 1'b0;
            ts_match      <= 1'b0;
            timeout_err   <= 1'b0;
            sys_id        <= '0;
            sys_timestamp <= '0;
        end else begin
            state     <= state_nxt;
            auto_pend <= 1'b0;

            if (state_nxt != state) begin
                stall_cnt <= '0;
            end else if (stall_en) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            if (lat_start) begin
                lat_cnt <= 2'd1;
            end else if ((state == S_LAT_ID) || (state == S_LAT_TS)) begin
                lat_cnt <= lat_cnt + 2'd1;
            end

            if (to_hit) begin
                to_flag <= 1'b1;
            end else if ((state_nxt == S_RD_ID) && (state != S_RD_ID)) begin
                to_flag <= 1'b0;
            end

            if (cap_id) begin
                sys_id <= avm_readdata;
            end
            if (cap_ts) begin
                sys_timestamp <= avm_readdata;
            end

            avm_read    <= (state_nxt == S_RD_ID) || (state_nxt == S_RD_TS);
            avm_address <= (state_nxt == S_RD_TS) || (state_nxt == S_LAT_TS);
            busy        <= (state_nxt == S_RD_ID) || (state_nxt == S_LAT_ID) ||
                           (state_nxt == S_RD_TS) || (state_nxt == S_LAT_TS);
            done        <= done_hold;
            timeout_err <= done_hold && to_flag;
            id_match    <= done_hold && !to_flag && (sys_id == EXPECTED_ID);
            ts_match    <= done_hold && !to_flag && (sys_timestamp == EXPECTED_TIMESTAMP);
        end
    end

endmodule
